// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Multi-cycle radix-2 restoring integer divider for DIV/DIVU.
//                Produces {remainder, quotient} after WIDTH+1 edges following
//                acceptance, or after one edge for a zero divisor.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   1        rising-edge clock
//    rst           in   1        asynchronous reset, active low
//    signed_div_i  in   1        1 = signed (DIV), 0 = unsigned (DIVU)
//    opdata1_i     in   WIDTH    dividend
//    opdata2_i     in   WIDTH    divisor
//    start_i       in   1        request, held until the result is consumed
//    annul_i       in   1        abort the current / pending operation
//    result_o      out  2*WIDTH  {remainder, quotient}, registered
//    ready_o       out  1        result valid, registered
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   dvd_q;      // dividend magnitude, consumed MSB first
    logic [WIDTH-1:0]   dvs_q;      // divisor magnitude
    logic [WIDTH-1:0]   rem_q;      // partial remainder (always < divisor)
    logic [WIDTH-1:0]   quot_q;
    logic               signed_q;
    logic               sign1_q;
    logic               sign2_q;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;

    logic [WIDTH-1:0]   abs1_d;
    logic [WIDTH-1:0]   abs2_d;
    logic [WIDTH:0]     shift_d;
    logic [WIDTH:0]     diff_d;
    logic               ge_d;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quot_d;
    logic [WIDTH-1:0]   quot_fix_d;
    logic [WIDTH-1:0]   rem_fix_d;

    always_comb begin
        abs1_d = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        abs2_d = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

        // The shifted partial remainder needs WIDTH+1 bits. Because the stored
        // remainder is below the divisor, shift_d < 2*divisor, so the trial
        // difference either fits in WIDTH bits (no borrow) or wraps with its
        // top bit set; that top bit is therefore the "less than" flag.
        shift_d = {rem_q, dvd_q[WIDTH-1]};
        diff_d  = shift_d - {1'b0, dvs_q};
        ge_d    = ~diff_d[WIDTH];
        rem_d   = ge_d ? diff_d[WIDTH-1:0] : shift_d[WIDTH-1:0];
        quot_d  = {quot_q[WIDTH-2:0], ge_d};

        // Truncation toward zero: quotient sign from the operand signs,
        // remainder sign from the dividend.
        quot_fix_d = (signed_q && (sign1_q ^ sign2_q)) ? -quot_q : quot_q;
        rem_fix_d  = (signed_q && sign1_q) ? -rem_q : rem_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_FREE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            signed_q <= 1'b0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_FREE: begin
                    ready_q  <= 1'b0;
                    result_q <= '0;
                    if (start_i && !annul_i) begin
                        dvd_q    <= abs1_d;
                        dvs_q    <= abs2_d;
                        rem_q    <= '0;
                        quot_q   <= '0;
                        cnt_q    <= '0;
                        signed_q <= signed_div_i;
                        sign1_q  <= opdata1_i[WIDTH-1];
                        sign2_q  <= opdata2_i[WIDTH-1];
                        state_q  <= (opdata2_i == '0) ? ST_BYZERO : ST_ON;
                    end
                end

                ST_BYZERO: begin
                    if (annul_i) begin
                        state_q <= ST_FREE;
                    end else begin
                        result_q <= '0;
                        ready_q  <= 1'b1;
                        state_q  <= ST_END;
                    end
                end

                ST_ON: begin
                    // Annul wins over the iteration in progress.
                    if (annul_i) begin
                        state_q <= ST_FREE;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                    end else if (cnt_q != CNT_LAST) begin
                        rem_q  <= rem_d;
                        quot_q <= quot_d;
                        dvd_q  <= {dvd_q[WIDTH-2:0], 1'b0};
                        cnt_q  <= cnt_q + 1'b1;
                    end else begin
                        result_q <= {rem_fix_d, quot_fix_d};
                        ready_q  <= 1'b1;
                        state_q  <= ST_END;
                    end
                end

                ST_END: begin
                    // Result is held for EX until it drops start; annul has
                    // no effect once the result is available.
                    if (!start_i) begin
                        state_q  <= ST_FREE;
                        ready_q  <= 1'b0;
                        result_q <= '0;
                    end
                end

                default: begin
                    state_q <= ST_FREE;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Self-checking bench for div_unit. Expected results are queued
//                when an operation is issued; a monitor pops and compares on
//                every rising edge of ready_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic prev_ready = 1'b0;

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (ready_o && !prev_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready: result=%h with no operation pending", result_o);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (result_o !== e) begin
                    errors++;
                    $display("FAIL result: got %h expected %h", result_o, e);
                end
            end
        end
        prev_ready = ready_o;
    end

    task automatic check_idle(input string name);
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++;
            $display("FAIL %s: ready=%b result=%h expected ready=0 result=0", name, ready_o, result_o);
        end
    endtask

    // Counts edges from acceptance until ready_o; scrambles the operands after
    // the acceptance edge, which must have no effect.
    task automatic wait_ready(input int exp_edges, input string name);
        int  edges = 0;
        bit  got   = 1'b0;
        while (!got && edges < 100) begin
            @(posedge clk);
            edges++;
            #1;
            if (ready_o) got = 1'b1;
            else if (edges == 1) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~signed_div_i;
            end
        end
        checks++;
        if (!got || edges != exp_edges) begin
            errors++;
            $display("FAIL %s_latency: got %0d edges (ready=%b) expected %0d", name, edges, got, exp_edges);
        end
    endtask

    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int exp_edges, input string name);
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        exp_q.push_back(exp);
        wait_ready(exp_edges, name);
        // Held in END while start stays high, annul ignored there
        repeat (2) begin
            @(negedge clk);
            annul_i = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (ready_o !== 1'b1 || result_o !== exp) begin
                errors++;
                $display("FAIL %s_hold: ready=%b result=%h expected ready=1 result=%h", name, ready_o, result_o, exp);
            end
        end
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check_idle({name, "_release"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #1;
        check_idle("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle("idle_after_reset");

        // start with annul in FREE is ignored (zero divisor would otherwise be ready after 2 edges)
        @(negedge clk);
        opdata1_i = 32'd5;
        opdata2_i = 32'd0;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("start_annul_free");
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;

        run_op(1'b0, 32'd100,        32'd7,        {32'd2,        32'd14},        34, "u_100_7");
        run_op(1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD},  34, "s_m7_2");
        run_op(1'b1, 32'd7,          32'hFFFFFFFE, {32'd1,        32'hFFFFFFFD},  34, "s_7_m2");
        run_op(1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, {32'hFFFFFFFF, 32'd3},         34, "s_m7_m2");
        run_op(1'b0, 32'd5,          32'd0,        64'd0,                         2,  "u_div0");
        run_op(1'b1, 32'hFFFFFFF9,   32'd0,        64'd0,                         2,  "s_div0");
        run_op(1'b1, 32'h80000000,   32'hFFFFFFFF, {32'd0,        32'h80000000},  34, "s_ovf");
        run_op(1'b0, 32'h80000000,   32'hFFFFFFFF, {32'h80000000, 32'd0},         34, "u_big");
        run_op(1'b0, 32'hFFFFFFFF,   32'd1,        {32'd0,        32'hFFFFFFFF},  34, "u_max_1");
        run_op(1'b0, 32'd7,          32'd100,      {32'd7,        32'd0},         34, "u_small");

        // Annul on iteration 10
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (10) @(posedge clk);   // E0..E9
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);               // E10 has passed
        annul_i = 1'b0;
        begin
            bit seen = 1'b0;
            repeat (40) begin
                @(posedge clk);
                #1;
                if (ready_o) seen = 1'b1;
            end
            checks++;
            if (seen) begin
                errors++;
                $display("FAIL annul: ready asserted=%b expected 0", seen);
            end
        end
        run_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34, "u_9_3_after_annul");

        // Asynchronous reset mid-ON
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_idle("reset_mid_on");
        start_i = 1'b0;
        #2;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("after_reset_mid_on");

        // Asynchronous reset in END, then a fresh operation right after release
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd20;
        opdata2_i    = 32'd6;
        start_i      = 1'b1;
        exp_q.push_back({32'd2, 32'd3});
        wait_ready(34, "u_20_6");
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_idle("reset_in_end");
        signed_div_i = 1'b1;
        opdata1_i    = 32'hFFFFFF9C;   // -100
        opdata2_i    = 32'd7;
        exp_q.push_back({32'hFFFFFFFE, 32'hFFFFFFF2});  // rem -2, quot -14
        #2;
        rst = 1'b1;
        wait_ready(34, "s_m100_7_after_reset");
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check_idle("final_release");

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending: %0d results never presented, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 integer divider with its own sequencing FSM. It serves the EX stage for DIV/DIVU.
- EX raises start_i with latched operands and asserts stallReq while start_i=1 and ready_o=0.
- The result returns as {remainder, quotient}, for writing to HI/LO downstream.
- The divider can be annulled when EX is flushed (exception, or mispredicted delay-slot context).

Parameters:
- WIDTH, 32, operand width; internal counter width is clog2(WIDTH)+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset asserted).
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- start_i  in  1  request; held high by EX until it has consumed the result.
- annul_i  in  1  abort the current/pending operation.
- result_o  out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}; registered.
- ready_o  out  1  result valid; registered.

Behaviour:
- Reset (rst=0, async):
  - state=FREE, cnt=0, result_o=0, ready_o=0, all internal registers 0.
  - Reset mid-operation discards the operation.
- States: FREE, BYZERO, ON, END.
- FREE:
  - ready_o=0, result_o=0.
  - On an edge with start_i=1 and annul_i=0:
    - If opdata2_i==0, go to BYZERO.
    - Otherwise go to ON, with cnt=0.
    - Latch |dividend| and |divisor|. Absolute value applies only when signed_div_i=1 and the MSB is set (two's-complement negate).
    - Latch signed_div_i and both operand sign bits.
  - start_i=1 with annul_i=1 is ignored.
- ON (one iteration per edge while cnt<WIDTH):
  - Partial remainder P (WIDTH+1 bits) shifts left by 1, taking in the next dividend bit, MSB first.
  - If P >= divisor: P = P - divisor and quotient bit = 1. Otherwise quotient bit = 0.
  - cnt increments.
  - On the edge where cnt==WIDTH, apply sign fix-up:
    - Negate the quotient if signed and the operand signs differ.
    - Negate the remainder if signed and the dividend was negative.
  - Load result_o, set ready_o=1, and go to END.
  - annul_i=1 on any ON edge: go to FREE, cnt=0, ready_o stays 0. Annul takes priority over the iteration.
- BYZERO:
  - Next edge: result_o=0, ready_o=1, go to END.
  - annul_i=1 instead goes to FREE.
- END:
  - Hold result_o and ready_o=1 while start_i=1; annul_i is ignored here.
  - On an edge with start_i=0: go to FREE, ready_o=0, result_o=0.
- Latency:
  - Start sampled at edge E0.
  - Normal operation: iterations at E1..E32, ready_o high after E33 (WIDTH+1 cycles of stall after acceptance).
  - Divide by zero: ready_o high after E1.
- Operand inputs are ignored after acceptance; changes mid-operation have no effect.
- Overflow case (signed 0x80000000 / 0xFFFFFFFF): quotient wraps to 0x80000000, remainder 0. No trap is raised.
- Remainder sign follows the dividend; quotient truncates toward zero (MIPS semantics).
- A back-to-back start needs start_i low for at least one edge (END to FREE) before the next acceptance.

Test Plan:
- Unsigned 100 / 7 (start held) -> ready_o rises after edge E33; result_o = {32'd2, 32'd14}. Drop start_i -> ready_o=0 and result_o=0 after the next edge.
- Signed -7 / 2 -> {0xFFFFFFFF, 0xFFFFFFFD} (rem -1, quot -3). Signed 7 / -2 -> {32'd1, 0xFFFFFFFD}.
- Divisor 0 (either signedness) -> ready_o high after E1, result_o=0. Stays in END while start_i=1.
- 0x80000000 / 0xFFFFFFFF:
  - Signed -> {0, 0x80000000}.
  - Unsigned -> {0x80000000, 0}.
- annul_i pulsed at iteration 10 -> FREE on that edge, ready_o never asserts. A new unsigned 9 / 3 then yields {0, 3} with full 33-edge latency.
- rst driven low asynchronously mid-ON (between edges) -> ready_o=0 and result_o=0 immediately. After release with start_i=1, a fresh operation begins on the first edge.
